c3lib_buf_seg_seq: RTL and testbench
====================================

C3LIB_BUF_SEG_SEQ -- requirements
Module: c3lib_buf_seg_seq

Interface
REQ-001 Parameter NUM_SEG, default 4: number of parallel buffer segments sequenced (legal 2..16).
REQ-002 Parameter DLY_W, default 4: width of the step-delay field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en_req  input  1  level request: 1 = all segments on, 0 = all segments off.
REQ-006 step_dly  input  DLY_W  cycles between segment steps, minus one; quasi-static.
REQ-007 seg_en  output  NUM_SEG  registered thermometer-coded segment enables, bit 0 first on, last off.
REQ-008 seq_busy  output  1  registered; high while ramping up or down.
REQ-009 seq_on  output  1  registered; high when all NUM_SEG segments are enabled.
REQ-010 seq_off  output  1  registered; high when no segment is enabled.

Function
REQ-011 The block SHALL keep a level register lvl (0..NUM_SEG) and a step counter cnt (DLY_W bits); seg_en SHALL equal the thermometer of lvl.
REQ-012 FSM states SHALL be IDLE (lvl=0), UP, ON (lvl=NUM_SEG), DN.
REQ-013 IDLE->UP and DN->UP SHALL occur on an edge sampling en_req=1; ON->DN and UP->DN on an edge sampling en_req=0; UP->ON when lvl reaches NUM_SEG; DN->IDLE when lvl reaches 0.
REQ-014 In UP/DN, each edge with cnt==dly_q SHALL step lvl by +1/-1 and clear cnt; otherwise cnt SHALL increment.
REQ-015 Leaving IDLE with cnt=0: segment k (0-based) SHALL assert exactly (k+1)*(step_dly+1) edges after the first edge sampling en_req=1.
REQ-016 Direction reversal mid-ramp: the reversal edge SHALL clear cnt with no lvl change; the first opposite step SHALL occur dly_q+1 edges later.
REQ-017 cnt SHALL be 0 in IDLE and ON.
REQ-018 step_dly SHALL be captured into dly_q on every edge in IDLE or ON; changes while in UP/DN SHALL be ignored until the ramp ends.
REQ-019 At most one segment SHALL change per edge; seg_en SHALL never be non-thermometer.
REQ-020 seq_busy = (state is UP or DN); seq_on = (lvl==NUM_SEG); seq_off = (lvl==0); all registered with seg_en, no extra latency.
REQ-021 en_req held 1 in ON or 0 in IDLE SHALL cause no state change.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, lvl=0, cnt=0, dly_q=step_dly, seg_en=0, seq_busy=0, seq_on=0, seq_off=1.
REQ-023 Reset mid-ramp SHALL drop all segments on that same edge (no ramp-down); rst has priority over en_req.

Configuration
REQ-024 Macro C3LIB_BUF_SEG_SEQ_BYPASS_EN: when defined, input seq_bypass (1 bit) exists; with seq_bypass=1, lvl SHALL jump to NUM_SEG or 0 on the edge sampling en_req=1 or 0, cnt held 0, seq_busy=0.
REQ-025 Without the macro, the port SHALL be absent and behaviour SHALL be the sequenced ramp only.

Verification
REQ-026 step_dly=0, en_req 0->1 -> seg_en 0001,0011,0111,1111 on edges 1..4; seq_on=1 and seq_busy=0 from edge 4.
REQ-027 step_dly=3, en_req=1 from ON-off -> seg_en[0] at edge 4, seg_en[3] at edge 16; then en_req=0 -> seg_en[3] clears at edge 4, seq_off at edge 16.
REQ-028 step_dly=2, en_req=1 until lvl=2, then en_req=0 -> reversal edge keeps 0011, 0001 three edges later, 0000 three more edges later, state IDLE.
REQ-029 step_dly changed 2->7 mid-ramp -> remaining steps still every 3 edges; next ramp uses 8-edge spacing.
REQ-030 rst=1 at lvl=3 during UP -> next edge seg_en=0000, seq_off=1, seq_busy=0; release with en_req=1 restarts at REQ-015 timing.
REQ-031 With C3LIB_BUF_SEG_SEQ_BYPASS_EN and seq_bypass=1, en_req 0->1 -> seg_en=1111 at edge 1, seq_busy never asserts.

Source files
------------

// File: rtl/c3lib_buf_seg_seq.sv
// c3lib_buf_seg_seq: thermometer-coded buffer segment enable sequencer.
// Ramps NUM_SEG segments on/off one at a time, spaced step_dly+1 cycles apart.
// Optional: define C3LIB_BUF_SEG_SEQ_BYPASS_EN to add seq_bypass, which jumps
// straight to all-on / all-off without ramping.
module c3lib_buf_seg_seq #(
    parameter int NUM_SEG = 4,
    parameter int DLY_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_req,
    input  logic [DLY_W-1:0]   step_dly,
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
    input  logic               seq_bypass,
`endif
    output logic [NUM_SEG-1:0] seg_en,
    output logic               seq_busy,
    output logic               seq_on,
    output logic               seq_off
);
    localparam int LW = $clog2(NUM_SEG + 1);
    localparam logic [LW-1:0] FULL = LW'(NUM_SEG);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] DN   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [LW-1:0]      lvl_q, lvl_d, lvl_n;
    logic [DLY_W-1:0]   cnt_q, cnt_d, dly_q, dly;
    logic [NUM_SEG-1:0] seg_d;
    logic               settled, moving, reverse, step;

    // Next-state: a settled state (IDLE/ON) starts ramping on the very edge that
    // samples the opposite request, using the live step_dly; a mid-ramp reversal
    // only restarts the step counter so the first opposite step is a full period.
    always_comb begin
        settled = (state_q == IDLE) || (state_q == ON);
        dly     = settled ? step_dly : dly_q;
        moving  = en_req ? (state_q == IDLE || state_q == UP) : (state_q == ON || state_q == DN);
        reverse = en_req ? (state_q == DN) : (state_q == UP);
        step    = moving && (cnt_q == dly);
        lvl_n   = en_req ? lvl_q + LW'(1) : lvl_q - LW'(1);
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        if (reverse) begin
            state_d = en_req ? UP : DN;
            cnt_d   = '0;
        end else if (step) begin
            lvl_d   = lvl_n;
            cnt_d   = '0;
            state_d = en_req ? ((lvl_n == FULL) ? ON : UP) : ((lvl_n == '0) ? IDLE : DN);
        end else if (moving) begin
            cnt_d   = cnt_q + DLY_W'(1);
            state_d = en_req ? UP : DN;
        end
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
        if (seq_bypass) begin
            lvl_d   = en_req ? FULL : '0;
            cnt_d   = '0;
            state_d = en_req ? ON : IDLE;
        end
`endif
        for (int i = 0; i < NUM_SEG; i++) seg_d[i] = int'(lvl_d) > i;
    end

    // State, counters and outputs; outputs are registered from the next-state so
    // they line up with lvl without extra latency. Delay is frozen while ramping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lvl_q    <= '0;
            cnt_q    <= '0;
            dly_q    <= step_dly;
            seg_en   <= '0;
            seq_busy <= 1'b0;
            seq_on   <= 1'b0;
            seq_off  <= 1'b1;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
            dly_q    <= settled ? step_dly : dly_q;
            seg_en   <= seg_d;
            seq_busy <= (state_d == UP) || (state_d == DN);
            seq_on   <= lvl_d == FULL;
            seq_off  <= lvl_d == '0;
        end
    end
endmodule

// File: tb/tb_c3lib_buf_seg_seq.sv
// tb_c3lib_buf_seg_seq: directed bench for the segment sequencer (NUM_SEG=4).
module tb_c3lib_buf_seg_seq;
    logic       clk = 1'b0;
    logic       rst, en_req;
    logic [3:0] step_dly;
    logic [3:0] seg_en;
    logic       seq_busy, seq_on, seq_off;
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
    logic       seq_bypass;
`endif
    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] obs, ex;

    always #5 clk = ~clk;

    c3lib_buf_seg_seq #(.NUM_SEG(4), .DLY_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .en_req(en_req),
        .step_dly(step_dly),
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
        .seq_bypass(seq_bypass),
`endif
        .seg_en(seg_en),
        .seq_busy(seq_busy),
        .seq_on(seq_on),
        .seq_off(seq_off)
    );

    assign obs = {seg_en, seq_busy, seq_on, seq_off};

    function automatic logic [6:0] expv(int l, logic b);
        logic [3:0] t;
        t = 4'((1 << l) - 1);
        return {t, b, l == 4, l == 0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en_req = 1'b1; step_dly = 4'd0;
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
        seq_bypass = 1'b0;
`endif
        tick; tick;
        n_cmp++;
        if (obs !== expv(0, 1'b0)) begin n_err++; $display("FAIL reset: got %b want %b", obs, expv(0, 1'b0)); end
        en_req = 1'b0; rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick;
            n_cmp++;
            if (obs !== expv(0, 1'b0)) begin n_err++; $display("FAIL idle_hold e%0d: got %b want %b", e, obs, expv(0, 1'b0)); end
        end
    endtask

    task automatic test_step0;
        step_dly = 4'd0; en_req = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick; ex = expv(e, e < 4);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL step0_up e%0d: got %b want %b", e, obs, ex); end
        end
        for (int e = 1; e <= 3; e++) begin
            tick;
            n_cmp++;
            if (obs !== expv(4, 1'b0)) begin n_err++; $display("FAIL on_hold e%0d: got %b want %b", e, obs, expv(4, 1'b0)); end
        end
        en_req = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick; ex = expv(4 - e, e < 4);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL step0_dn e%0d: got %b want %b", e, obs, ex); end
        end
    endtask

    task automatic test_step3;
        step_dly = 4'd3; tick;
        en_req = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick; ex = expv(e / 4, e < 16);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL step3_up e%0d: got %b want %b", e, obs, ex); end
        end
        en_req = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick; ex = expv(4 - e / 4, e < 16);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL step3_dn e%0d: got %b want %b", e, obs, ex); end
        end
    endtask

    task automatic test_reversal;
        step_dly = 4'd2; en_req = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick; ex = expv(e / 3, 1'b1);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL rev_up e%0d: got %b want %b", e, obs, ex); end
        end
        en_req = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick; ex = expv((k >= 6) ? 0 : 2 - k / 3, k < 6);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL rev_dn k%0d: got %b want %b", k, obs, ex); end
        end
    endtask

    task automatic test_dly_change;
        step_dly = 4'd2; en_req = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) step_dly = 4'd7;
            tick; ex = expv(e / 3, e < 12);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL dlychg_up e%0d: got %b want %b", e, obs, ex); end
        end
        tick;
        en_req = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick; ex = expv(4 - e / 8, e < 32);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL dlychg_dn e%0d: got %b want %b", e, obs, ex); end
        end
    endtask

    task automatic test_reset_mid;
        step_dly = 4'd1; en_req = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick; ex = expv(e / 2, 1'b1);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL rstmid_up e%0d: got %b want %b", e, obs, ex); end
        end
        rst = 1'b1; tick;
        n_cmp++;
        if (obs !== expv(0, 1'b0)) begin n_err++; $display("FAIL rstmid_drop: got %b want %b", obs, expv(0, 1'b0)); end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick; ex = expv(e / 2, e < 8);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL rstmid_restart e%0d: got %b want %b", e, obs, ex); end
        end
        en_req = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick; ex = expv(4 - e / 2, e < 8);
            n_cmp++;
            if (obs !== ex) begin n_err++; $display("FAIL rstmid_dn e%0d: got %b want %b", e, obs, ex); end
        end
    endtask

`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
    task automatic test_bypass;
        step_dly = 4'd3; seq_bypass = 1'b1; en_req = 1'b1;
        tick;
        n_cmp++;
        if (obs !== expv(4, 1'b0)) begin n_err++; $display("FAIL bypass_on: got %b want %b", obs, expv(4, 1'b0)); end
        en_req = 1'b0; tick;
        n_cmp++;
        if (obs !== expv(0, 1'b0)) begin n_err++; $display("FAIL bypass_off: got %b want %b", obs, expv(0, 1'b0)); end
        seq_bypass = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_step0;
        test_step3;
        test_reversal;
        test_dly_change;
        test_reset_mid;
`ifdef C3LIB_BUF_SEG_SEQ_BYPASS_EN
        test_bypass;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
